issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 7 +
 rtl/issue_scheduler_age_picker.sv | 28 ++
 rtl/issue_scheduler.sv | 88 ++++++++
 tb/tb_issue_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared sizing constants for the issue scheduler
package issue_scheduler_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int NUM_FU = 3;
  localparam int ROB_W = 6;
  localparam int RS_W = 4;
endpackage

// File: rtl/issue_scheduler_age_picker.sv
// age_picker: oldest requesting entry by ROB distance from head, lower index wins ties
module age_picker
  import issue_scheduler_pkg::*;
#(
  parameter int N = NUM_ENTRIES
) (
  input  logic [N-1:0]       req,
  input  logic [ROB_W*N-1:0] rob_idx,
  input  logic [ROB_W-1:0]   rob_head,
  output logic               valid,
  output logic [RS_W-1:0]    idx
);
  logic [ROB_W-1:0] age, best;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    best = '0;
    age = '0;
    for (int i = 0; i < N; i++) begin
      age = rob_idx[i*ROB_W +: ROB_W] - rob_head;
      if (req[i] && (!valid || age < best)) begin
        valid = 1'b1;
        idx = RS_W'(i);
        best = age;
      end
    end
  end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered multi-FU issue arbiter with LS throttling and round-robin FU assignment
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_ENTRIES = issue_scheduler_pkg::NUM_ENTRIES,
  parameter int NUM_FU = issue_scheduler_pkg::NUM_FU
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_ENTRIES-1:0]   req_ready,
  input  logic [NUM_ENTRIES-1:0]   req_is_ls,
  input  logic [ROB_W*NUM_ENTRIES-1:0] req_rob_idx,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic                     ls_addr_ack,
  output logic [NUM_FU-1:0]        fu_issue_valid,
  output logic [RS_W*NUM_FU-1:0]   fu_issue_entry,
  output logic [NUM_ENTRIES-1:0]   entry_issued,
  output logic [NUM_FU-1:0]        fu_busy
);
  localparam int PTR_W = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  logic [PTR_W-1:0] rr_ptr, rr_next;
  logic ls_outstanding, ls_grant;
  logic [NUM_FU-1:0] free, gv, pick_v;
  logic [RS_W*NUM_FU-1:0] ge, pick_idx;
  logic [NUM_ENTRIES-1:0] gmask, base_mask;
  assign free = ~fu_busy | fu_done;
  assign base_mask = req_ready & ~entry_issued & ((ls_outstanding && !ls_addr_ack) ? ~req_is_ls : '1);
  for (genvar k = 0; k < NUM_FU; k++) begin : stage
    logic [NUM_ENTRIES-1:0] m;
    logic v;
    logic [RS_W-1:0] idx;
    if (k == 0) begin : g_first
      assign m = base_mask;
    end else begin : g_next
      assign m = stage[k-1].m & ~(NUM_ENTRIES'(stage[k-1].v) << stage[k-1].idx)
               & ((stage[k-1].v && req_is_ls[stage[k-1].idx]) ? ~req_is_ls : '1);
    end
    age_picker #(.N(NUM_ENTRIES)) u_pick (
      .req(m),
      .rob_idx(req_rob_idx),
      .rob_head(rob_head),
      .valid(v),
      .idx(idx)
    );
    assign pick_v[k] = v;
    assign pick_idx[k*RS_W +: RS_W] = idx;
  end
  always_comb begin
    int f, c;
    gv = '0;
    ge = '0;
    gmask = '0;
    ls_grant = 1'b0;
    rr_next = rr_ptr;
    c = 0;
    f = 0;
    for (int o = 0; o < NUM_FU; o++) begin
      f = (int'(rr_ptr) + o) % NUM_FU;
      if (!flush && free[f] && pick_v[c]) begin
        gv[f] = 1'b1;
        ge[f*RS_W +: RS_W] = pick_idx[c*RS_W +: RS_W];
        gmask[pick_idx[c*RS_W +: RS_W]] = 1'b1;
        ls_grant = ls_grant | req_is_ls[pick_idx[c*RS_W +: RS_W]];
        rr_next = PTR_W'((f + 1) % NUM_FU);
        c++;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fu_issue_valid <= '0;
      fu_issue_entry <= '0;
      entry_issued <= '0;
      fu_busy <= '0;
      rr_ptr <= '0;
      ls_outstanding <= 1'b0;
    end else begin
      fu_issue_valid <= gv;
      fu_issue_entry <= ge;
      entry_issued <= gmask;
      fu_busy <= flush ? '0 : gv | (fu_busy & ~fu_done);
      rr_ptr <= flush ? '0 : rr_next;
      ls_outstanding <= !flush && (ls_grant || (ls_outstanding && !ls_addr_ack));
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed vector table plus multi-cycle sequences for issue_scheduler
module tb_issue_scheduler;
  localparam int NE = 16;
  localparam int NF = 3;
  typedef struct packed {
    logic        flush;
    logic [15:0] ready;
    logic [15:0] ls;
    logic [23:0] rob_lo;
    logic [5:0]  head;
    logic [2:0]  v;
    logic [11:0] e;
    logic [15:0] iss;
    logic [2:0]  b;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic ls_addr_ack = 1'b0;
  logic [NE-1:0] req_ready = '0;
  logic [NE-1:0] req_is_ls = '0;
  logic [6*NE-1:0] req_rob_idx;
  logic [5:0] rob_head = '0;
  logic [5:0] rob [NE];
  logic [NF-1:0] fu_done = '0;
  logic [NF-1:0] fu_issue_valid, fu_busy;
  logic [4*NF-1:0] fu_issue_entry;
  logic [NE-1:0] entry_issued;
  int checks = 0;
  int failures = 0;
  vec_t vt [8];
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < NE; i++) req_rob_idx[i*6 +: 6] = rob[i];
  issue_scheduler #(.NUM_ENTRIES(NE), .NUM_FU(NF)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .req_ready(req_ready),
    .req_is_ls(req_is_ls),
    .req_rob_idx(req_rob_idx),
    .rob_head(rob_head),
    .fu_done(fu_done),
    .ls_addr_ack(ls_addr_ack),
    .fu_issue_valid(fu_issue_valid),
    .fu_issue_entry(fu_issue_entry),
    .entry_issued(entry_issued),
    .fu_busy(fu_busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic expect_out(input string n, input logic [2:0] v, input logic [11:0] e,
                            input logic [15:0] iss, input logic [2:0] b, input logic full);
    logic [11:0] m;
    m = full ? 12'hFFF : {{4{v[2]}}, {4{v[1]}}, {4{v[0]}}};
    check({n, "_valid"}, 32'(fu_issue_valid), 32'(v));
    if (m != 12'h000) check({n, "_entry"}, 32'(fu_issue_entry & m), 32'(e & m));
    check({n, "_issued"}, 32'(entry_issued), 32'(iss));
    check({n, "_busy"}, 32'(fu_busy), 32'(b));
  endtask
  task automatic idle();
    req_ready = '0;
    req_is_ls = '0;
    fu_done = '0;
    ls_addr_ack = 1'b0;
    flush = 1'b0;
    rob_head = '0;
    for (int i = 0; i < NE; i++) rob[i] = 6'(i);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    idle();
    vt[0] = '{1'b0, 16'h000F, 16'h0000, {6'd0, 6'd1, 6'd2, 6'd3}, 6'd0, 3'b111, 12'h123, 16'h000E, 3'b111};
    vt[1] = '{1'b0, 16'h0003, 16'h0000, {6'd3, 6'd2, 6'd62, 6'd2}, 6'd60, 3'b011, 12'h001, 16'h0003, 3'b011};
    vt[2] = '{1'b0, 16'h0005, 16'h0000, {6'd3, 6'd5, 6'd1, 6'd5}, 6'd0, 3'b011, 12'h020, 16'h0005, 3'b011};
    vt[3] = '{1'b0, 16'h0007, 16'h0003, {6'd3, 6'd2, 6'd1, 6'd0}, 6'd0, 3'b011, 12'h020, 16'h0005, 3'b011};
    vt[4] = '{1'b0, 16'h0000, 16'h0000, {6'd3, 6'd2, 6'd1, 6'd0}, 6'd0, 3'b000, 12'h000, 16'h0000, 3'b000};
    vt[5] = '{1'b0, 16'hFFF0, 16'h0000, {6'd3, 6'd2, 6'd1, 6'd0}, 6'd4, 3'b111, 12'h654, 16'h0070, 3'b111};
    vt[6] = '{1'b1, 16'h000F, 16'h0000, {6'd3, 6'd2, 6'd1, 6'd0}, 6'd0, 3'b000, 12'h000, 16'h0000, 3'b000};
    vt[7] = '{1'b0, 16'h0003, 16'h0003, {6'd3, 6'd2, 6'd0, 6'd1}, 6'd0, 3'b001, 12'h001, 16'h0002, 3'b001};
    for (int n = 0; n < 8; n++) begin
      idle();
      req_ready = vt[n].ready;
      req_is_ls = vt[n].ls;
      for (int i = 0; i < 4; i++) rob[i] = vt[n].rob_lo[6*i +: 6];
      rob_head = vt[n].head;
      flush = vt[n].flush;
      reset = 1'b1;
      step();
      expect_out($sformatf("vec%0d_rst", n), 3'b000, 12'h000, 16'h0000, 3'b000, 1'b1);
      reset = 1'b0;
      step();
      expect_out($sformatf("vec%0d", n), vt[n].v, vt[n].e, vt[n].iss, vt[n].b, 1'b0);
    end
    idle();
    do_reset();
    req_ready = 16'h0070;
    step();
    expect_out("s1_fill", 3'b111, 12'h654, 16'h0070, 3'b111, 1'b0);
    fu_done = 3'b101;
    step();
    expect_out("s1_pend", 3'b000, 12'h000, 16'h0000, 3'b010, 1'b0);
    fu_done = 3'b000;
    req_ready = 16'h000C;
    rob[2] = 6'd10;
    rob[3] = 6'd9;
    step();
    expect_out("s1_rr", 3'b101, 12'h203, 16'h000C, 3'b111, 1'b0);
    req_ready = 16'h0080;
    fu_done = 3'b111;
    step();
    expect_out("s1_ptr", 3'b001, 12'h007, 16'h0080, 3'b001, 1'b0);
    idle();
    do_reset();
    req_ready = 16'h0007;
    req_is_ls = 16'h0003;
    step();
    expect_out("s2_ls1", 3'b011, 12'h020, 16'h0005, 3'b011, 1'b0);
    req_ready = 16'h0002;
    fu_done = 3'b011;
    step();
    expect_out("s2_block", 3'b000, 12'h000, 16'h0000, 3'b000, 1'b0);
    fu_done = 3'b000;
    ls_addr_ack = 1'b1;
    step();
    expect_out("s2_ack", 3'b100, 12'h100, 16'h0002, 3'b100, 1'b0);
    ls_addr_ack = 1'b0;
    req_ready = 16'h0010;
    req_is_ls = 16'h0010;
    step();
    expect_out("s2_hold", 3'b000, 12'h000, 16'h0000, 3'b100, 1'b0);
    ls_addr_ack = 1'b1;
    step();
    expect_out("s2_ack2", 3'b001, 12'h004, 16'h0010, 3'b101, 1'b0);
    ls_addr_ack = 1'b0;
    req_ready = 16'h0000;
    flush = 1'b1;
    step();
    expect_out("s2_flush", 3'b000, 12'h000, 16'h0000, 3'b000, 1'b0);
    flush = 1'b0;
    req_ready = 16'h0040;
    req_is_ls = 16'h0040;
    step();
    expect_out("s2_lsclr", 3'b001, 12'h006, 16'h0040, 3'b001, 1'b0);
    idle();
    do_reset();
    req_ready = 16'h0007;
    step();
    expect_out("s3_fill", 3'b111, 12'h210, 16'h0007, 3'b111, 1'b0);
    req_ready = 16'h0020;
    fu_done = 3'b010;
    step();
    expect_out("s3_bypass", 3'b010, 12'h050, 16'h0020, 3'b111, 1'b0);
    fu_done = 3'b000;
    req_ready = 16'h002F;
    flush = 1'b1;
    step();
    expect_out("s3_flush", 3'b000, 12'h000, 16'h0000, 3'b000, 1'b0);
    flush = 1'b0;
    req_ready = 16'h0020;
    step();
    expect_out("s3_after", 3'b001, 12'h005, 16'h0020, 3'b001, 1'b0);
    req_ready = 16'h0000;
    fu_done = 3'b110;
    step();
    expect_out("s3_spurious_done", 3'b000, 12'h000, 16'h0000, 3'b001, 1'b0);
    fu_done = 3'b000;
    req_ready = 16'h000F;
    flush = 1'b1;
    reset = 1'b1;
    step();
    expect_out("s4_rst_prio", 3'b000, 12'h000, 16'h0000, 3'b000, 1'b1);
    reset = 1'b0;
    flush = 1'b0;
    req_ready = 16'h0000;
    step();
    expect_out("s4_post", 3'b000, 12'h000, 16'h0000, 3'b000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
